// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
// Holds the debounce FSM states, frame classes, the "no key" code and the 4x4 legend map.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE_DB
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_class_e;

    // All-ones at any code width; users slice the low KEY_W bits.
    localparam logic [31:0] KEY_NONE = '1;

    localparam logic [4:0] LEGEND [16] = '{
        5'd1,  5'd2, 5'd3,  5'd10,
        5'd4,  5'd5, 5'd6,  5'd11,
        5'd7,  5'd8, 5'd9,  5'd12,
        5'd15, 5'd0, 5'd14, 5'd13
    };

    function automatic logic [4:0] legend_4x4(input logic [1:0] r, input logic [1:0] c);
        return LEGEND[{r, c}];
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Key event channel: valid/ready handshake plus held level, release and overrun strobes.
interface keypad_if #(
    parameter int KEY_W = 5
) ();
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ready;
    logic             key_held;
    logic             key_release;
    logic             overrun;

    modport master (
        output key_code, key_valid, key_held, key_release, overrun,
        input  key_ready
    );

    modport slave (
        input  key_code, key_valid, key_held, key_release, overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_row_scanner.sv
// Scan-rate divider, one-hot row drive and whole-frame column capture.
// frame_bits bit r*COLS+c is row r / column c; it is valid in the frame_done cycle.
module keypad_row_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 6000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COLS-1:0]      col_bits,
    output logic [ROWS-1:0]      fila,
    output logic                 frame_done,
    output logic [ROWS*COLS-1:0] frame_bits
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [DIV_W-1:0]     div_q, div_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [ROWS-1:0]      fila_q, fila_d;
    logic [ROWS*COLS-1:0] acc_q, acc_d;
    logic                 scan_tick;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        scan_tick = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d     = scan_tick ? '0 : div_q + DIV_W'(1);
        row_d     = row_q;
        acc_d     = acc_q;
        if (scan_tick) begin
            acc_d[int'(row_q)*COLS +: COLS] = col_bits;
            row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
        end
        fila_d = '0;
        fila_d[ROWS-1-int'(row_d)] = 1'b1;
        frame_done = scan_tick && (row_q == ROW_W'(ROWS - 1));
        frame_bits = acc_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            row_q  <= '0;
            fila_q <= ROWS'(1) << (ROWS - 1);
            acc_q  <= '0;
        end else begin
            div_q  <= div_d;
            row_q  <= row_d;
            fila_q <= fila_d;
            acc_q  <= acc_d;
        end
    end

    assign fila = fila_q;
endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad front end: column synchroniser, frame classifier, press/release
// debounce FSM and a single-entry event register behind a valid/ready handshake.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 6000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int KEY_W          = 5,
    parameter int MAP_LEGEND     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] columna,
    output logic [ROWS-1:0] fila,
    keypad_if.master        evt
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [COLS-1:0]  sync1_q, sync2_q, col_bits;
    logic             frame_done;
    logic [N-1:0]     frame_bits;
    frame_class_e     frame_class;
    logic [IDX_W-1:0] hit_idx;
    int               hits;

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic             confirm;
    logic             valid_q, valid_d, overrun_q, overrun_d, release_q, release_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             accept;

    function automatic logic [KEY_W-1:0] code_of(input logic [IDX_W-1:0] idx);
        int unsigned r, c;
        r = int'(idx) / COLS;
        c = int'(idx) % COLS;
        if (MAP_LEGEND == 1 && ROWS == 4 && COLS == 4)
            return KEY_W'(legend_4x4(r[1:0], c[1:0]));
        return KEY_W'(idx);
    endfunction

    // Column pins are wired in reverse order relative to the column index.
    always_comb begin
        for (int c = 0; c < COLS; c++) col_bits[c] = sync2_q[COLS-1-c];
    end

    keypad_row_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_bits   (col_bits),
        .fila       (fila),
        .frame_done (frame_done),
        .frame_bits (frame_bits)
    );

    always_comb begin
        hits    = 0;
        hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (frame_bits[i]) begin
                hits++;
                hit_idx = IDX_W'(i);
            end
        end
        frame_class = (hits == 0) ? FR_NONE : (hits == 1) ? FR_SINGLE : FR_MULTI;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        confirm   = 1'b0;
        release_d = 1'b0;
        if (frame_done) begin
            unique case (state_q)
                IDLE: if (frame_class == FR_SINGLE) begin
                    cand_d  = hit_idx;
                    cnt_d   = CNT_W'(1);
                    confirm = (DEBOUNCE_SCANS == 1);
                    state_d = confirm ? PRESSED : DEBOUNCE;
                end
                DEBOUNCE: if (frame_class == FR_SINGLE && hit_idx == cand_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
                        confirm = 1'b1;
                        state_d = PRESSED;
                    end
                end else if (frame_class == FR_SINGLE) begin
                    cand_d = hit_idx;
                    cnt_d  = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
                PRESSED: if (frame_class == FR_NONE) begin
                    cnt_d     = CNT_W'(1);
                    release_d = (DEBOUNCE_SCANS == 1);
                    state_d   = release_d ? IDLE : RELEASE_DB;
                end
                RELEASE_DB: if (frame_class == FR_NONE) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(DEBOUNCE_SCANS)) begin
                        release_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = PRESSED;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // An accept in the same cycle frees the slot, so a simultaneous confirm loads instead of overrunning.
    always_comb begin
        accept    = valid_q && evt.key_ready;
        valid_d   = valid_q;
        code_d    = code_q;
        overrun_d = 1'b0;
        if (accept) begin
            valid_d = 1'b0;
            code_d  = KEY_NONE[KEY_W-1:0];
        end
        if (confirm) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                code_d  = code_of(cand_d);
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            valid_q   <= 1'b0;
            code_q    <= KEY_NONE[KEY_W-1:0];
            overrun_q <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= columna;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
            release_q <= release_d;
        end
    end

    assign evt.key_code    = code_q;
    assign evt.key_valid   = valid_q;
    assign evt.key_held    = (state_q == PRESSED) || (state_q == RELEASE_DB);
    assign evt.key_release = release_q;
    assign evt.overrun     = overrun_q;
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce: behavioural 4x4 matrix, event scoreboard
// for a legend-mapped instance and a raw-index instance.
module tb_keypad_scan_debounce;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DSC = 3, KEY_W = 5;
    localparam int LAT  = (DSC + 1) * ROWS * SCAN_DIV + 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [15:0]     pressed1 = '0, pressed2 = '0;
    logic [COLS-1:0] col1, col2;
    logic [ROWS-1:0] fila1, fila2;

    keypad_if #(.KEY_W(KEY_W)) ev1 ();
    keypad_if #(.KEY_W(KEY_W)) ev2 ();

    keypad_scan_debounce #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DSC),
                           .KEY_W(KEY_W), .MAP_LEGEND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .columna(col1), .fila(fila1), .evt(ev1));

    keypad_scan_debounce #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DSC),
                           .KEY_W(KEY_W), .MAP_LEGEND(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .columna(col2), .fila(fila2), .evt(ev2));

    always #5 clk = ~clk;

    // Key (r,c) shorts row fila[3-r] onto column columna[3-c].
    always_comb begin
        col1 = '0;
        col2 = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (pressed1[r*COLS+c] && fila1[ROWS-1-r]) col1[COLS-1-c] = 1'b1;
                if (pressed2[r*COLS+c] && fila2[ROWS-1-r]) col2[COLS-1-c] = 1'b1;
            end
    end

    int n_chk = 0, n_fail = 0;
    int ev1_cnt = 0, ev2_cnt = 0, rel1 = 0, ovr1 = 0;
    int q1[$], q2[$];
    logic prev_v1, prev_r1, prev_v2, prev_r2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; the scoreboard pops whenever an event register loads.
    task automatic tick();
        int exp;
        prev_v1 = ev1.key_valid; prev_r1 = ev1.key_ready;
        prev_v2 = ev2.key_valid; prev_r2 = ev2.key_ready;
        @(negedge clk);
        if (ev1.key_valid && (!prev_v1 || prev_r1)) begin
            ev1_cnt++;
            exp = (q1.size() > 0) ? q1.pop_front() : 32'hDEAD;
            check("dut1 event code", 32'(ev1.key_code), exp);
        end
        if (ev2.key_valid && (!prev_v2 || prev_r2)) begin
            ev2_cnt++;
            exp = (q2.size() > 0) ? q2.pop_front() : 32'hDEAD;
            check("dut2 event code", 32'(ev2.key_code), exp);
        end
        if (ev1.key_release) rel1++;
        if (ev1.overrun) ovr1++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_ev1(input int base, input string tag);
        int k = 0;
        while (ev1_cnt == base && k < LAT) begin tick(); k++; end
        check(tag, ev1_cnt, base + 1);
    endtask

    initial begin
        int k;
        ev1.key_ready = 1'b1;
        ev2.key_ready = 1'b1;
        #1 rst_n = 1'b0;
        run(3);
        check("reset fila", 32'(fila1), 4'b1000);
        check("reset key_code", 32'(ev1.key_code), 31);
        check("reset key_valid", 32'(ev1.key_valid), 0);
        check("reset key_held", 32'(ev1.key_held), 0);
        check("reset key_release", 32'(ev1.key_release), 0);
        check("reset overrun", 32'(ev1.overrun), 0);
        check("reset dut2 key_code", 32'(ev2.key_code), 31);

        rst_n = 1'b1;
        check("walk row0", 32'(fila1), 4'b1000);
        run(4); check("walk row1", 32'(fila1), 4'b0100);
        run(4); check("walk row2", 32'(fila1), 4'b0010);
        run(4); check("walk row3", 32'(fila1), 4'b0001);
        run(4); check("walk wrap", 32'(fila1), 4'b1000);

        // Clean press of (r0,c0) with the consumer always ready.
        q1.push_back(1);
        pressed1 = 16'h0001;
        wait_ev1(0, "press r0c0 latency");
        run(16);
        check("r0c0 held", 32'(ev1.key_held), 1);
        check("r0c0 valid single pulse", 32'(ev1.key_valid), 0);
        pressed1 = '0;
        run(32);
        check("release not early", rel1, 0);
        run(36);
        check("release strobe", rel1, 1);
        check("released held", 32'(ev1.key_held), 0);

        // Stalled consumer: second confirmed press overruns.
        ev1.key_ready = 1'b0;
        q1.push_back(15);
        pressed1 = 16'h1000;
        wait_ev1(1, "press r3c0 latency");
        check("r3c0 valid", 32'(ev1.key_valid), 1);
        check("r3c0 code", 32'(ev1.key_code), 15);
        pressed1 = '0;
        run(80);
        check("r3c0 released", 32'(ev1.key_held), 0);
        check("valid persists after release", 32'(ev1.key_valid), 1);
        pressed1 = 16'h0004;
        run(80);
        check("overrun strobe", ovr1, 1);
        check("code kept on overrun", 32'(ev1.key_code), 15);
        check("no event on overrun", ev1_cnt, 2);
        ev1.key_ready = 1'b1;
        tick();
        check("accept clears valid", 32'(ev1.key_valid), 0);
        check("accept clears code", 32'(ev1.key_code), 31);
        pressed1 = '0;
        run(80);

        // Bouncing (r1,c2) alternates every frame, then settles.
        for (int i = 0; i < 6; i++) begin
            pressed1 = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            run(16);
        end
        check("bounce no event", ev1_cnt, 2);
        q1.push_back(6);
        pressed1 = 16'h0040;
        wait_ev1(2, "stable r1c2 latency");
        pressed1 = '0;
        run(80);

        // Two keys in one frame never confirm.
        pressed1 = 16'h0202;
        run(96);
        check("multi no event", ev1_cnt, 3);
        check("multi not held", 32'(ev1.key_held), 0);
        pressed1 = '0;
        run(32);

        // Raw-index instance: (r3,c3) -> 15.
        q2.push_back(15);
        pressed2 = 16'h8000;
        k = 0;
        while (ev2_cnt == 0 && k < LAT) begin tick(); k++; end
        check("raw r3c3 event", ev2_cnt, 1);
        pressed2 = '0;
        run(80);

        // Reset while debouncing.
        pressed1 = 16'h0100;
        run(32);
        check("debounce not yet held", 32'(ev1.key_held), 0);
        rst_n = 1'b0;
        pressed1 = '0;
        tick();
        check("mid-debounce reset fila", 32'(fila1), 4'b1000);
        check("mid-debounce reset code", 32'(ev1.key_code), 31);
        rst_n = 1'b1;
        run(96);
        check("no event after debounce reset", ev1_cnt, 3);

        // Reset while an event is pending.
        ev1.key_ready = 1'b0;
        q1.push_back(7);
        pressed1 = 16'h0100;
        wait_ev1(3, "press r2c0 latency");
        check("r2c0 pending", 32'(ev1.key_valid), 1);
        rst_n = 1'b0;
        pressed1 = '0;
        tick();
        check("pending reset valid", 32'(ev1.key_valid), 0);
        check("pending reset code", 32'(ev1.key_code), 31);
        check("pending reset held", 32'(ev1.key_held), 0);
        rst_n = 1'b1;
        run(96);
        check("no stale event valid", 32'(ev1.key_valid), 0);
        check("no stale event count", ev1_cnt, 4);

        check("dut1 scoreboard drained", q1.size(), 0);
        check("dut2 scoreboard drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
